next_pc_stage: RTL
==================

Name: next_pc_stage

Overview:
- Front-end stage directly upstream of the fetch stage: owns the architectural fetch PC register.
- Each cycle it presents one aligned fetch group (head PC plus per-lane valids) to the fetch stage.
- It selects the next PC by priority: recovery, then a pending redirect, then the taken prediction returned by the fetch stage's BTB/RAS/PHT, then the sequential address.
- It handles the stall, reset-start and taken-branch squash behaviour.

Parameters:
FETCH_WIDTH, 2, lanes per fetch group (power of 2); group = FETCH_WIDTH*4 bytes
PC_WIDTH, 32, PC bits
RESET_PC, 32'h0000_1000, first fetch address after reset start

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rstStart  in  1  high while post-reset initialisation (cache/predictor clear) runs; fetch must not start
stall  in  1  fetch stage cannot accept a new group
recoveryValid  in  1  backend misprediction/exception redirect
recoveryPC  in  PC_WIDTH  redirect target
fsValid  in  FETCH_WIDTH  fetch-stage lane valid
fsBtbHit  in  FETCH_WIDTH  BTB hit per fetch-stage lane
fsBtbOut  in  FETCH_WIDTH*PC_WIDTH  BTB target per lane
fsBrPredTaken  in  FETCH_WIDTH  predicted taken per lane
fsRasPop  in  FETCH_WIDTH  lane is a return (RAS pop)
fsRasOut  in  FETCH_WIDTH*PC_WIDTH  RAS target per lane
npPC  out  PC_WIDTH  head PC of group sent to fetch stage
npLanePC  out  FETCH_WIDTH*PC_WIDTH  per-lane PC (aligned base + 4*k)
npValid  out  FETCH_WIDTH  per-lane valid of presented group
npSquash  out  1  presented group is wrong-path this cycle

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values, while rst is high: state=NP_RESET, pcReg=RESET_PC, pendValid=0, pendPC=0, npValid all 0, npSquash=0.
- NP_RESET → NP_WAIT on the first clk edge after rst deasserts.
- NP_WAIT → NP_RUN on the first cycle rstStart=0. In NP_WAIT, pcReg stays RESET_PC and npValid=0.
- NP_RUN → NP_PEND when the fetch-stage redirect is taken and stall=1. NP_PEND → NP_RUN when stall=0 or recoveryValid=1.
- Lane valid: npValid[k]=1 iff state∈{NP_RUN,NP_PEND}, not squashed, and k ≥ pcReg[log2(FETCH_WIDTH)+1:2]. Lanes below the unaligned entry offset are invalid.
- Sequential next: seqPC = (pcReg with low log2(FETCH_WIDTH)+2 bits cleared) + FETCH_WIDTH*4, modulo 2^PC_WIDTH (wrap silently).
- Fetch-stage redirect: take the lowest lane i with fsValid[i]&fsBtbHit[i]&fsBrPredTaken[i]. Target = fsRasPop[i] ? fsRasOut[i] : fsBtbOut[i]. No such lane → no redirect.
- pcReg update priority in NP_RUN/NP_PEND, latency 1 cycle:
  1. recoveryValid: pcReg←recoveryPC; pendValid←0; npSquash=1 this cycle. Ignores stall.
  2. stall=0 and pendValid: pcReg←pendPC; pendValid←0; npSquash=1.
  3. stall=0 and fetch redirect: pcReg←target; npSquash=1. This gives a one-bubble taken penalty.
  4. stall=0: pcReg←seqPC.
  5. stall=1 and fetch redirect and !pendValid: pendPC←target; pendValid←1; pcReg holds.
  6. stall=1 otherwise: everything holds.
- While pendValid=1, new fetch-stage redirects are ignored; the first captured redirect wins.
- npSquash forces npValid to all 0 in the same cycle.
- rst asserted mid-operation: immediate return to reset values; any pending redirect is lost.
- recoveryValid in NP_RESET/NP_WAIT: ignored.

Decomposition:
- Shared package (FetchUnitTypes): NextPCStateType enum {NP_RESET, NP_WAIT, NP_RUN, NP_PEND}, PC_Path, FETCH_GROUP_BYTES and INSN_BYTE_OFFSET constants, and a ToGroupBase() function.
- One sub-module, np_redirect_select: a combinational priority encoder over lanes producing redirect valid and target.
- Top-level pipeline connection goes through the existing NextPCStage modport.

Test Plan (FETCH_WIDTH=2, RESET_PC=0x1000):
1. rst pulse, rstStart high 3 cycles then low → npValid=00 until rstStart falls; then npPC 0x1000/0x1008/0x1010 on consecutive cycles, npValid=11.
2. recoveryValid with recoveryPC=0x2004 → next cycle npPC=0x2004, npValid=10 (lane1 only), npLanePC={0x2000,0x2004}; following cycle 0x2008, valid 11.
3. While pcReg=0x1010, fs lane1 valid, BTB hit, taken, fsBtbOut=0x3000 → same cycle npSquash=1, npValid=00; next cycle npPC=0x3000.
4. Lanes 0 and 1 both taken; lane0 has fsRasPop=1, fsRasOut=0x4000, fsBtbOut=0x5000 → next npPC=0x4000 (lowest lane, RAS selected).
5. stall high 3 cycles; redirect to 0x3000 in the first stall cycle, redirect to 0x6000 in the second → pcReg holds, state NP_PEND; stall falls → next npPC=0x3000, 0x6000 dropped.
6. In NP_PEND with stall=1, recoveryValid with 0x7000 → next npPC=0x7000, pendValid=0, state NP_RUN; stall then falls with no redirect → 0x7008.

Source files
------------

// File: rtl/next_pc_stage_pkg.sv
// FetchUnitTypes: shared fetch front-end types, constants and PC helpers.
package FetchUnitTypes;
    localparam int PC_PATH_WIDTH = 32;
    localparam int FETCH_GROUP_LANES = 2;
    localparam int INSN_BYTE_OFFSET = 2;
    localparam int FETCH_GROUP_BYTES = FETCH_GROUP_LANES * 4;

    typedef logic [PC_PATH_WIDTH-1:0] PC_Path;

    typedef enum logic [1:0] {NP_RESET, NP_WAIT, NP_RUN, NP_PEND} NextPCStateType;

    // Clears the in-group byte offset; fetchWidth lanes of 4-byte instructions per group.
    function automatic logic [63:0] ToGroupBase(input logic [63:0] pc, input int fetchWidth);
        return pc & ~((64'(fetchWidth) << INSN_BYTE_OFFSET) - 64'd1);
    endfunction
endpackage

// File: rtl/next_pc_stage_redirect_select.sv
// np_redirect_select: picks the lowest predicted-taken lane and its BTB or RAS target.
module np_redirect_select #(
    parameter int FETCH_WIDTH = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic [FETCH_WIDTH-1:0]          fsValid,
    input  logic [FETCH_WIDTH-1:0]          fsBtbHit,
    input  logic [FETCH_WIDTH-1:0]          fsBrPredTaken,
    input  logic [FETCH_WIDTH-1:0]          fsRasPop,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] fsBtbOut,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] fsRasOut,
    output logic                            redirValid,
    output logic [PC_WIDTH-1:0]             redirTarget
);
    logic [FETCH_WIDTH-1:0] taken;

    assign taken = fsValid & fsBtbHit & fsBrPredTaken;

    // Scan from the top lane down so the lowest taken lane is written last and wins.
    always_comb begin
        redirValid = 1'b0;
        redirTarget = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (taken[i]) begin
                redirValid = 1'b1;
                redirTarget = fsRasPop[i] ? fsRasOut[i*PC_WIDTH +: PC_WIDTH] : fsBtbOut[i*PC_WIDTH +: PC_WIDTH];
            end
        end
    end
endmodule

// File: rtl/next_pc_stage.sv
// next_pc_stage: owns the fetch PC, presents aligned fetch groups and chooses the next PC
// by recovery > pending redirect > fetch-stage prediction > sequential.
module next_pc_stage
    import FetchUnitTypes::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rstStart,
    input  logic                            stall,
    input  logic                            recoveryValid,
    input  logic [PC_WIDTH-1:0]             recoveryPC,
    input  logic [FETCH_WIDTH-1:0]          fsValid,
    input  logic [FETCH_WIDTH-1:0]          fsBtbHit,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] fsBtbOut,
    input  logic [FETCH_WIDTH-1:0]          fsBrPredTaken,
    input  logic [FETCH_WIDTH-1:0]          fsRasPop,
    input  logic [FETCH_WIDTH*PC_WIDTH-1:0] fsRasOut,
    output logic [PC_WIDTH-1:0]             npPC,
    output logic [FETCH_WIDTH*PC_WIDTH-1:0] npLanePC,
    output logic [FETCH_WIDTH-1:0]          npValid,
    output logic                            npSquash
);
    NextPCStateType state, nextState;
    logic [PC_WIDTH-1:0] pcReg, nextPC, pendPC, nextPendPC;
    logic [PC_WIDTH-1:0] pcBase, seqPC, laneOffset, redirTarget;
    logic pendValid, nextPendValid, redirValid, active;

    np_redirect_select #(.FETCH_WIDTH(FETCH_WIDTH), .PC_WIDTH(PC_WIDTH)) redirectSelect (
        .fsValid(fsValid),
        .fsBtbHit(fsBtbHit),
        .fsBrPredTaken(fsBrPredTaken),
        .fsRasPop(fsRasPop),
        .fsBtbOut(fsBtbOut),
        .fsRasOut(fsRasOut),
        .redirValid(redirValid),
        .redirTarget(redirTarget)
    );

    assign active = state == NP_RUN || state == NP_PEND;
    assign pcBase = PC_WIDTH'(ToGroupBase(64'(pcReg), FETCH_WIDTH));
    assign seqPC = pcBase + PC_WIDTH'(FETCH_WIDTH * 4);
    assign laneOffset = (pcReg >> INSN_BYTE_OFFSET) & PC_WIDTH'(FETCH_WIDTH - 1);
    assign npPC = pcReg;

    // Lanes before the entry offset of an unaligned target are not part of the path.
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : gLane
        assign npValid[k] = active && !npSquash && laneOffset <= PC_WIDTH'(k);
        assign npLanePC[k*PC_WIDTH +: PC_WIDTH] = pcBase + PC_WIDTH'(4 * k);
    end

    always_comb begin
        nextState = state;
        nextPC = pcReg;
        nextPendPC = pendPC;
        nextPendValid = pendValid;
        npSquash = 1'b0;
        if (state == NP_RESET) begin
            nextState = NP_WAIT;
        end else if (state == NP_WAIT) begin
            nextState = rstStart ? NP_WAIT : NP_RUN;
        end else if (recoveryValid) begin
            nextState = NP_RUN;
            nextPC = recoveryPC;
            nextPendValid = 1'b0;
            npSquash = 1'b1;
        end else if (!stall) begin
            nextState = NP_RUN;
            nextPC = pendValid ? pendPC : redirValid ? redirTarget : seqPC;
            nextPendValid = 1'b0;
            npSquash = pendValid || redirValid;
        end else if (redirValid && !pendValid) begin
            // Stalled redirect is parked; later redirects are ignored until it drains.
            nextState = NP_PEND;
            nextPendPC = redirTarget;
            nextPendValid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NP_RESET;
            pcReg <= RESET_PC;
            pendValid <= 1'b0;
            pendPC <= '0;
        end else begin
            state <= nextState;
            pcReg <= nextPC;
            pendValid <= nextPendValid;
            pendPC <= nextPendPC;
        end
    end
endmodule
